// File: rtl/bit_count_launcher.sv
// Pushbutton-launched handshake to a slow-clock bit counter: debounced go,
// stale-done rejection, timeout abort and a long command-low release window.
module bit_count_launcher #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned TIMEOUT_CYCLES  = 1_000_000_000,
  parameter int unsigned HOLD_CYCLES     = 250_000_000
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic       btn_go,
  input  logic [3:0] sw_data,
  input  logic       done,
  input  logic [2:0] ones_in,
  output logic       command,
  output logic [3:0] dataA,
  output logic [2:0] result,
  output logic       result_valid,
  output logic       err_timeout,
  output logic       busy,
  output logic [2:0] state_out
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HD_W = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_WAIT = 3'd2,
    S_REL  = 3'd3
  } state_t;

  logic            btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
  logic            done_s1_q, done_s1_d, done_s2_q, done_s2_d;
  logic            btn_db_q, btn_db_d, btn_db_prev_q, btn_db_prev_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  state_t          state_q, state_d;
  logic [TO_W-1:0] tmr_q, tmr_d;
  logic [HD_W-1:0] hold_q, hold_d;
  logic [3:0]      dataA_q, dataA_d;
  logic [2:0]      result_q, result_d;
  logic            result_valid_q, result_valid_d;
  logic            err_timeout_q, err_timeout_d;
  logic            go_pulse, done_sync, tmo;

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      btn_s1_q       <= 1'b0;
      btn_s2_q       <= 1'b0;
      done_s1_q      <= 1'b0;
      done_s2_q      <= 1'b0;
      btn_db_q       <= 1'b0;
      btn_db_prev_q  <= 1'b0;
      db_cnt_q       <= '0;
      state_q        <= S_IDLE;
      tmr_q          <= '0;
      hold_q         <= '0;
      dataA_q        <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      btn_s1_q       <= btn_s1_d;
      btn_s2_q       <= btn_s2_d;
      done_s1_q      <= done_s1_d;
      done_s2_q      <= done_s2_d;
      btn_db_q       <= btn_db_d;
      btn_db_prev_q  <= btn_db_prev_d;
      db_cnt_q       <= db_cnt_d;
      state_q        <= state_d;
      tmr_q          <= tmr_d;
      hold_q         <= hold_d;
      dataA_q        <= dataA_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      err_timeout_q  <= err_timeout_d;
    end
  end

  // Synchronizers and debounce: the count only survives an unbroken mismatch run.
  always_comb begin
    btn_s1_d      = btn_go;
    btn_s2_d      = btn_s1_q;
    done_s1_d     = done;
    done_s2_d     = done_s1_q;
    btn_db_d      = btn_db_q;
    db_cnt_d      = '0;
    btn_db_prev_d = btn_db_q;
    if (btn_s2_q != btn_db_q) begin
      if (db_cnt_q >= DB_W'(DEBOUNCE_CYCLES - 1)) btn_db_d = btn_s2_q;
      else                                        db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  assign go_pulse  = btn_db_q & ~btn_db_prev_q;
  assign done_sync = done_s2_q;
  assign tmo       = (tmr_q >= TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d        = state_q;
    tmr_d          = tmr_q;
    hold_d         = hold_q;
    dataA_d        = dataA_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    err_timeout_d  = err_timeout_q;
    command        = 1'b0;
    busy           = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (go_pulse) begin
          dataA_d        = sw_data;
          result_valid_d = 1'b0;
          err_timeout_d  = 1'b0;
          tmr_d          = '0;
          state_d        = S_ARM;
        end
      end
      S_ARM: begin
        command = 1'b1;
        tmr_d   = tmr_q + TO_W'(1);
        // Wait for done to drop so a leftover done=1 is never captured.
        if (!done_sync) begin
          state_d = S_WAIT;
        end else if (tmo) begin
          err_timeout_d = 1'b1;
          hold_d        = '0;
          state_d       = S_REL;
        end
      end
      S_WAIT: begin
        command = 1'b1;
        tmr_d   = tmr_q + TO_W'(1);
        if (done_sync) begin
          result_d       = ones_in;
          result_valid_d = 1'b1;
          err_timeout_d  = 1'b0;
          hold_d         = '0;
          state_d        = S_REL;
        end else if (tmo) begin
          err_timeout_d = 1'b1;
          hold_d        = '0;
          state_d       = S_REL;
        end
      end
      S_REL: begin
        if (hold_q >= HD_W'(HOLD_CYCLES - 1)) state_d = S_IDLE;
        else                                  hold_d  = hold_q + HD_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dataA        = dataA_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign err_timeout  = err_timeout_q;
  assign state_out    = state_q;

endmodule

// File: tb/tb_bit_count_launcher.sv
// Bench for bit_count_launcher: the bench plays the downstream bit counter
// (ones_in = popcount of the launched operand) and checks transaction-level rules.
module tb_bit_count_launcher;
  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       btn = 1'b0;
  logic [3:0] sw = 4'd0;
  logic       done = 1'b0;
  logic [2:0] ones = 3'd0;
  logic       command, result_valid, err_timeout, busy;
  logic [3:0] dataA;
  logic [2:0] result, state_out;

  int total = 0;
  int bad = 0;
  int cap_cnt = 0;
  logic rv_prev = 1'b0;

  bit_count_launcher #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(64), .HOLD_CYCLES(8)) dut (
    .CLK100MHZ(clk), .CPU_RESETN(rstn), .btn_go(btn), .sw_data(sw), .done(done),
    .ones_in(ones), .command(command), .dataA(dataA), .result(result),
    .result_valid(result_valid), .err_timeout(err_timeout), .busy(busy),
    .state_out(state_out));

  always #5 clk = ~clk;

  // Capture monitor: count result_valid rising edges.
  always @(negedge clk) begin
    if (result_valid === 1'b1 && rv_prev !== 1'b1) cap_cnt++;
    rv_prev <= result_valid;
  end

  // Press the button ~11 cycles; return negedges until command first seen high.
  task automatic launch(input logic [3:0] s, output int lat);
    sw = s; btn = 1'b1; lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (command === 1'b1 && lat == 0) lat = i;
      if (i == 11) btn = 1'b0;
      if (lat != 0 && i >= 11) break;
    end
    btn = 1'b0;
  endtask

  // Downstream reports completion; wait (bounded) for command to drop.
  task automatic complete(input logic [2:0] o, output int w);
    ones = o; done = 1'b1; w = 0;
    while (command === 1'b1 && w < 10) begin @(negedge clk); w++; end
  endtask

  // Count busy cycles left (RELEASE), then the downstream lowers done.
  task automatic wait_idle(output int h, output bit cmd_seen);
    h = 0; cmd_seen = 0;
    while (busy === 1'b1 && h < 30) begin
      if (command !== 1'b0) cmd_seen = 1;
      h++; @(negedge clk);
    end
    done = 1'b0; ones = 3'd0;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (command !== 1'b0) begin bad++; $display("FAIL reset_command got=%b exp=0", command); end
    total++; if (dataA !== 4'd0) begin bad++; $display("FAIL reset_dataA got=%h exp=0", dataA); end
    total++; if (result !== 3'd0) begin bad++; $display("FAIL reset_result got=%0d exp=0", result); end
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL reset_rv got=%b exp=0", result_valid); end
    total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_timeout); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (state_out !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_out); end
    rstn = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_normal;
    int lat, w, h, k; bit cs;
    logic [3:0] s; logic [2:0] exp;
    for (int n = 0; n < 5; n++) begin
      s = (n == 0) ? 4'b1011 : 4'($urandom_range(0, 15));
      exp = 3'($countones(s));
      launch(s, lat);
      total++; if (lat < 6 || lat > 8) begin bad++; $display("FAIL normal_latency got=%0d exp=6..8", lat); end
      total++; if (dataA !== s) begin bad++; $display("FAIL normal_dataA got=%h exp=%h", dataA, s); end
      k = $urandom_range(0, 20);
      repeat (k) @(negedge clk);
      total++; if (state_out !== 3'd2) begin bad++; $display("FAIL normal_wait_state got=%0d exp=2", state_out); end
      complete(exp, w);
      total++; if (command !== 1'b0) begin bad++; $display("FAIL normal_cmd_fall got=%b exp=0", command); end
      total++; if (result !== exp || result_valid !== 1'b1) begin
        bad++; $display("FAIL normal_result got=%0d/%b exp=%0d/1", result, result_valid, exp); end
      total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL normal_err got=%b exp=0", err_timeout); end
      wait_idle(h, cs);
      total++; if (h != 8 || cs) begin bad++; $display("FAIL normal_hold got=%0d cmd=%0d exp=8 cmd=0", h, cs); end
      repeat (4) @(negedge clk);
      total++; if (result !== exp || result_valid !== 1'b1 || busy !== 1'b0) begin
        bad++; $display("FAIL normal_persist got=%0d/%b busy=%b exp=%0d/1 busy=0", result, result_valid, busy, exp); end
    end
  endtask

  task automatic test_bounce;
    bit seen = 0;
    for (int i = 0; i < 20; i++) begin
      btn = ((i / 2) % 2 == 0);
      @(negedge clk);
      if (command !== 1'b0 || busy !== 1'b0) seen = 1;
    end
    btn = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (command !== 1'b0 || busy !== 1'b0) seen = 1;
    end
    total++; if (seen) begin bad++; $display("FAIL bounce_launch got=launched exp=none"); end
    total++; if (state_out !== 3'd0) begin bad++; $display("FAIL bounce_state got=%0d exp=0", state_out); end
  endtask

  task automatic test_stale_done;
    int lat, w, h, k; bit cs, not_arm, rv_seen;
    logic [3:0] s; logic [2:0] exp;
    s = 4'($urandom_range(0, 15)); exp = 3'($countones(s));
    done = 1'b1; ones = 3'd7;
    repeat (3) @(negedge clk);
    launch(s, lat);
    not_arm = 0; rv_seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (state_out !== 3'd1) not_arm = 1;
      if (result_valid !== 1'b0) rv_seen = 1;
      @(negedge clk);
    end
    total++; if (not_arm) begin bad++; $display("FAIL stale_arm got=left_arm exp=stay_arm state=%0d", state_out); end
    total++; if (rv_seen) begin bad++; $display("FAIL stale_capture got=captured exp=none"); end
    done = 1'b0;
    k = 0;
    while (state_out !== 3'd2 && k < 10) begin @(negedge clk); k++; end
    total++; if (state_out !== 3'd2) begin bad++; $display("FAIL stale_to_wait got=%0d exp=2", state_out); end
    complete(exp, w);
    total++; if (result !== exp || result_valid !== 1'b1) begin
      bad++; $display("FAIL stale_result got=%0d/%b exp=%0d/1", result, result_valid, exp); end
    wait_idle(h, cs);
  endtask

  task automatic test_timeout;
    int c, h; bit cs, up;
    done = 1'b0; sw = 4'($urandom_range(0, 15)); btn = 1'b1;
    c = 0; up = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (i == 11) btn = 1'b0;
      if (command === 1'b1) begin c++; up = 1; end
      else if (up) break;
    end
    btn = 1'b0;
    total++; if (c != 64) begin bad++; $display("FAIL timeout_cycles got=%0d exp=64", c); end
    total++; if (err_timeout !== 1'b1 || result_valid !== 1'b0) begin
      bad++; $display("FAIL timeout_flags got=err%b/rv%b exp=err1/rv0", err_timeout, result_valid); end
    total++; if (state_out !== 3'd3) begin bad++; $display("FAIL timeout_release got=%0d exp=3", state_out); end
    wait_idle(h, cs);
    total++; if (h != 8 || state_out !== 3'd0 || err_timeout !== 1'b1) begin
      bad++; $display("FAIL timeout_idle got=hold%0d st%0d err%b exp=hold8 st0 err1", h, state_out, err_timeout); end
  endtask

  task automatic test_reset_mid;
    int lat, w, h; bit cs;
    logic [3:0] s; logic [2:0] exp;
    launch(4'($urandom_range(0, 15)), lat);
    total++; if (state_out !== 3'd2) begin bad++; $display("FAIL rmid_pre got=%0d exp=2", state_out); end
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    total++; if (command !== 1'b0 || state_out !== 3'd0 || result !== 3'd0 || result_valid !== 1'b0) begin
      bad++; $display("FAIL rmid_abort got=cmd%b st%0d res%0d rv%b exp=cmd0 st0 res0 rv0",
                      command, state_out, result, result_valid); end
    repeat (3) @(negedge clk);
    s = 4'($urandom_range(0, 15)); exp = 3'($countones(s));
    launch(s, lat);
    total++; if (lat < 6 || lat > 8) begin bad++; $display("FAIL rmid_relaunch got=%0d exp=6..8", lat); end
    complete(exp, w);
    total++; if (result !== exp || result_valid !== 1'b1) begin
      bad++; $display("FAIL rmid_result got=%0d/%b exp=%0d/1", result, result_valid, exp); end
    wait_idle(h, cs);
  endtask

  task automatic test_back_to_back;
    int lat, w, h, c0; bit cs, moved, relaunch;
    logic [3:0] a; logic [2:0] exp;
    a = 4'($urandom_range(0, 15)); exp = 3'($countones(a));
    done = 1'b0;
    launch(a, lat);
    c0 = cap_cnt;
    sw = ~a; btn = 1'b1; moved = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (dataA !== a || state_out !== 3'd2) moved = 1;
    end
    btn = 1'b0;
    repeat (8) @(negedge clk);
    total++; if (moved || dataA !== a) begin bad++; $display("FAIL b2b_dataA got=%h exp=%h", dataA, a); end
    complete(exp, w);
    wait_idle(h, cs);
    relaunch = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) relaunch = 1;
    end
    total++; if (cap_cnt - c0 != 1) begin bad++; $display("FAIL b2b_captures got=%0d exp=1", cap_cnt - c0); end
    total++; if (relaunch || result !== exp) begin
      bad++; $display("FAIL b2b_queued got=relaunch%0d res%0d exp=relaunch0 res%0d", relaunch, result, exp); end
  endtask

  initial begin
    test_reset;
    test_normal;
    test_bounce;
    test_stale_done;
    test_timeout;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bit_count_launcher.md
BIT_COUNT_LAUNCHER -- requirements
Module: bit_count_launcher

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1_000_000, consecutive stable cycles required to accept a new button level (10 ms at 100 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 1_000_000_000, maximum cycles spent in ARM plus WAIT_DONE before abort.
REQ-003 Parameter HOLD_CYCLES, default 250_000_000, cycles command is held low in RELEASE.
REQ-004 CLK100MHZ  in  1  sole clock; all state updates on its rising edge.
REQ-005 CPU_RESETN  in  1  reset, synchronous, active-low.
REQ-006 btn_go  in  1  raw pushbutton, asynchronous and bouncy.
REQ-007 sw_data  in  4  operand switches, asynchronous.
REQ-008 done  in  1  completion flag from the downstream bit counter, on a slower clock; treated as asynchronous.
REQ-009 ones_in  in  3  ones count from the downstream bit counter; valid while done=1.
REQ-010 command  out  1  start request to the bit counter.
REQ-011 dataA  out  4  operand to the bit counter.
REQ-012 result  out  3  captured ones count.
REQ-013 result_valid  out  1  result holds a completed count.
REQ-014 err_timeout  out  1  last launch aborted on timeout.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 state_out  out  3  state encoding for display: IDLE=0, ARM=1, WAIT_DONE=2, RELEASE=3.

Function
REQ-017 btn_go and done each pass through a 2-flop synchronizer before use; sw_data is sampled only at launch.
REQ-018 Debounce: btn_db takes the synchronized btn_go level only after that level differs from btn_db for DEBOUNCE_CYCLES consecutive cycles; any mismatch-break restarts the count.
REQ-019 go_pulse is a one-cycle pulse on the 0->1 transition of btn_db; go_pulse outside IDLE is ignored and not queued.
REQ-020 IDLE: command=0; on go_pulse, latch sw_data into dataA, clear result_valid and err_timeout, clear the timer, move to ARM.
REQ-021 ARM: command=1; on done_sync=0 move to WAIT_DONE, which rejects a stale done=1 left over from the previous run.
REQ-022 WAIT_DONE: command=1; on done_sync=1, capture ones_in into result, set result_valid=1, move to RELEASE.
REQ-023 Timer increments every cycle in ARM and WAIT_DONE; when it reaches TIMEOUT_CYCLES-1 without a transition, set err_timeout=1, leave result and result_valid unchanged (0), move to RELEASE.
REQ-024 RELEASE: command=0; hold for exactly HOLD_CYCLES cycles, then move to IDLE. This guarantees the slow downstream clock samples command=0.
REQ-025 dataA is constant from leaving IDLE until the next launch.
REQ-026 result, result_valid and err_timeout persist through RELEASE and IDLE until the next go_pulse.
REQ-027 Counter widths accommodate the largest parameter without wrap; no counter wraps in normal operation.
REQ-028 Unused state encodings go to IDLE on the next cycle with command=0.
REQ-029 If a timeout and done_sync=1 occur on the same cycle in WAIT_DONE, done wins: capture result, err_timeout=0.

Reset
REQ-030 While CPU_RESETN=0 at a clock edge, the block enters IDLE and sets these outputs: command=0, dataA=0, result=0, result_valid=0, err_timeout=0, busy=0, state_out=0.
REQ-031 Reset also clears the debounce, timer and hold counters, and sets btn_db=0 and both synchronizers to 0.
REQ-032 Reset mid-operation (any state) aborts the launch with no result captured; command=0 on the cycle after the reset edge.

Verification
All scenarios use DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=64, HOLD_CYCLES=8.
REQ-033 Normal run: sw_data=4'b1011, btn_go high 10 cycles, done 0 then 1 with ones_in=3 -> the following must hold:
  - command rises about 6-7 cycles after the button;
  - on done, result=3 and result_valid=1;
  - command=0 for 8 cycles, then busy=0.
REQ-034 Bounce: btn_go toggles every 2 cycles for 20 cycles, then goes low -> no launch; command stays 0, busy=0.
REQ-035 Stale done: done held 1 at the time of go -> the block stays in ARM (state_out=1) until done=0, and no capture occurs before that.
REQ-036 Timeout: go with done held 0 forever -> after 64 cycles, err_timeout=1, result_valid=0, and the block passes through RELEASE to IDLE.
REQ-037 Reset in WAIT_DONE with CPU_RESETN=0 for 1 cycle -> next cycle command=0, state_out=0, result=0; a later go launches normally.
REQ-038 Second press while busy -> ignored; dataA unchanged; exactly one capture per launch.
